output_ram_responder: RTL and testbench
=======================================

OUTPUT_RAM_RESPONDER -- requirements
Module: output_ram_responder

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
  ADDR_W, 3, output-RAM address width; depth is 2**ADDR_W = 8.
  DATA_W, 16, word width.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock; all state changes on its rising edge.
  reset  in  1  asynchronous, active-low reset.
  xxx__dut__go  in  1  run-start pulse; clears capture state.
  dut__xxx__finish  in  1  accelerator-done pulse.
  dut__dom__address  in  ADDR_W  write/read address from the accelerator.
  dut__dom__data  in  DATA_W  write data.
  dut__dom__enable  in  1  access strobe.
  dut__dom__write  in  1  1 = write, 0 = read.
  dom__dut__data  out  DATA_W  read data.
  dump_valid  out  1  dump word available.
  dump_ready  in  1  consumer accepts the dump word.
  dump_address  out  ADDR_W  address of the dump word.
  dump_data  out  DATA_W  dump word.
  dump_done  out  1  all 8 words accepted.
  written_mask  out  8  bit i set = address i written this run.
  overwrite_err  out  1  sticky flag (check build only).
  missing_err  out  1  sticky flag (check build only).
  late_write_err  out  1  sticky flag (check build only).

Function
REQ-003 The storage SHALL be an 8 x DATA_W register array.
REQ-004 Writes: in CAPTURE, when enable=1 and write=1, the block SHALL store mem[address] <= data and set written_mask[address].
REQ-005 Reads: when enable=1 and write=0, dom__dut__data SHALL equal mem[address] one cycle later; otherwise dom__dut__data SHALL hold its last value.
REQ-006 A read and a write to the same address are never simultaneous on the single port; a read of an address written in the previous cycle SHALL return the new data.
REQ-007 The FSM SHALL have the states CAPTURE (reset state), DUMP and DONE.
REQ-008 CAPTURE -> DUMP SHALL occur on finish=1; a write in the same cycle SHALL be committed before the dump starts.
REQ-009 In DUMP, a 3-bit pointer SHALL start at 0, and the block SHALL drive dump_valid=1, dump_address=ptr and dump_data=mem[ptr] combinationally from registered state.
REQ-010 A dump word SHALL be accepted when dump_valid and dump_ready are both 1; on acceptance the pointer increments.
REQ-011 While dump_ready=0, dump_address and dump_data SHALL hold.
REQ-012 Acceptance at ptr=7 SHALL move the FSM to DONE: dump_valid=0, dump_done=1, pointer wraps to 0.
REQ-013 The minimum dump latency SHALL be 8 cycles, with one word per cycle under constant ready.
REQ-014 In DONE, dump_done SHALL stay 1 until go; further finish pulses are ignored.
REQ-015 go=1 in any state SHALL return the FSM to CAPTURE; clear written_mask, dump_done and all error flags; zero the pointer; and leave mem unchanged. go has priority over finish and over a same-cycle write, which is dropped.
REQ-016 Writes in DUMP or DONE SHALL be ignored (mem and mask unchanged); reads remain serviced in every state.
REQ-017 A finish pulse while in DUMP SHALL be ignored.

Reset
REQ-018 Asserting reset low SHALL immediately set:
  FSM=CAPTURE, pointer=0, written_mask=0, dump_valid=0, dump_done=0;
  dom__dut__data=0, all error flags=0, every mem word=0.
REQ-019 Reset asserted mid-dump SHALL abort the dump with no further dump_valid.

Configuration
REQ-020 With macro DOM_RESPONDER_CHECK_EN defined, the error flags SHALL behave as follows:
  overwrite_err sets on a CAPTURE write to an address whose mask bit is already 1;
  missing_err sets on the finish cycle if the mask (including a same-cycle write) is not 8'hFF;
  late_write_err sets on any write attempt in DUMP or DONE.
REQ-021 Without DOM_RESPONDER_CHECK_EN, all three flags SHALL be constant 0, no checker logic shall be synthesized, and all other behaviour is identical.

Verification
REQ-022 Full run with constant ready: reset, go, write addr i with data 16'h0100+i for i=0..7, then finish -> mask=8'hFF; 8 dump words (0,16'h0100)..(7,16'h0107) on consecutive cycles; dump_done=1 on the cycle after the 8th acceptance; no errors.
REQ-023 Backpressure: hold ready=0 for 3 cycles at ptr=2 -> address 2 and data 16'h0102 stable; dump resumes in order; total 11 cycles.
REQ-024 Check build, missing and overwrite: write addr 5 twice (16'hAAAA then 16'hBBBB) and never write addr 3, then finish -> overwrite_err=1, missing_err=1, dump word 5 = 16'hBBBB, word 3 = 16'h0000.
REQ-025 Late write and restart: in DUMP, write addr 0 with 16'hFFFF -> mem[0] unchanged, late_write_err=1 (check build); then go -> mask=0, flags=0, dump_done=0, state CAPTURE.
REQ-026 Reset mid-dump: drive reset low at ptr=4 -> dump_valid=0 immediately, dump_done=0, readback of any address = 16'h0000.
REQ-027 Simultaneous events: go and finish in the same cycle -> CAPTURE, no dump; write plus finish in the same cycle -> the written word appears in the dump.

Source files
------------

// File: rtl/output_ram_responder.sv
// Output RAM responder: captures accelerator writes into an 8-word register
// array, then streams every word out on a valid/ready dump port after finish.
// Optional protocol checker enabled by defining DOM_RESPONDER_CHECK_EN.
module output_ram_responder #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      xxx__dut__go,
   input  logic                      dut__xxx__finish,
   input  logic [ADDR_W-1:0]         dut__dom__address,
   input  logic [DATA_W-1:0]         dut__dom__data,
   input  logic                      dut__dom__enable,
   input  logic                      dut__dom__write,
   output logic [DATA_W-1:0]         dom__dut__data,
   output logic                      dump_valid,
   input  logic                      dump_ready,
   output logic [ADDR_W-1:0]         dump_address,
   output logic [DATA_W-1:0]         dump_data,
   output logic                      dump_done,
   output logic [(1<<ADDR_W)-1:0]    written_mask,
   output logic                      overwrite_err,
   output logic                      missing_err,
   output logic                      late_write_err
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {StCapture, StDump, StDone} state_e;

   state_e                   state_q, state_d;
   logic [ADDR_W-1:0]        ptr_q, ptr_d;
   logic [DEPTH-1:0]         mask_q, mask_d;
   logic [DEPTH-1:0]         addr_bit;
   logic [DATA_W-1:0]        mem_q [DEPTH];
   logic [DATA_W-1:0]        rdata_q;
   logic                     wr_en;
   logic                     rd_en;
   logic                     wr_attempt;

   // go wins over everything, so a write in the go cycle is dropped
   assign wr_attempt = dut__dom__enable & dut__dom__write & ~xxx__dut__go;
   assign wr_en      = wr_attempt & (state_q == StCapture);
   assign rd_en      = dut__dom__enable & ~dut__dom__write;
   assign addr_bit   = DEPTH'(1) << dut__dom__address;

   // Next-state, dump pointer and written-mask update
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mask_d  = mask_q;
      if (xxx__dut__go) begin
         state_d = StCapture;
         ptr_d   = '0;
         mask_d  = '0;
      end else begin
         if (wr_en) mask_d = mask_q | addr_bit;
         unique case (state_q)
            StCapture: begin
               if (dut__xxx__finish) begin
                  state_d = StDump;
                  ptr_d   = '0;
               end
            end
            StDump: begin
               if (dump_ready) begin
                  ptr_d = ptr_q + 1'b1;
                  if (ptr_q == LAST_PTR) state_d = StDone;
               end
            end
            StDone: ;
            default: begin
               state_d = StCapture;
               ptr_d   = '0;
            end
         endcase
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StCapture;
         ptr_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         mask_q  <= mask_d;
      end
   end

   // Storage array: written only in capture, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[dut__dom__address] <= dut__dom__data;
      end
   end

   // Registered read port; holds its value when no read is issued
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         rdata_q <= mem_q[dut__dom__address];
      end
   end

   assign dom__dut__data = rdata_q;
   assign dump_valid     = (state_q == StDump);
   assign dump_done      = (state_q == StDone);
   assign dump_address   = ptr_q;
   assign dump_data      = mem_q[ptr_q];
   assign written_mask   = mask_q;

`ifdef DOM_RESPONDER_CHECK_EN
   logic overwrite_q;
   logic missing_q;
   logic late_q;

   // Sticky protocol error flags, cleared by go
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overwrite_q <= 1'b0;
         missing_q   <= 1'b0;
         late_q      <= 1'b0;
      end else if (xxx__dut__go) begin
         overwrite_q <= 1'b0;
         missing_q   <= 1'b0;
         late_q      <= 1'b0;
      end else begin
         if (wr_en && ((mask_q & addr_bit) != '0)) overwrite_q <= 1'b1;
         // mask_d already includes a same-cycle write
         if ((state_q == StCapture) && dut__xxx__finish && (mask_d != '1)) missing_q <= 1'b1;
         if (wr_attempt && (state_q != StCapture)) late_q <= 1'b1;
      end
   end

   assign overwrite_err  = overwrite_q;
   assign missing_err    = missing_q;
   assign late_write_err = late_q;
`else
   assign overwrite_err  = 1'b0;
   assign missing_err    = 1'b0;
   assign late_write_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_ram_responder.sv
// Directed bench for output_ram_responder with a dump-word scoreboard.
module tb_output_ram_responder;

`ifdef DOM_RESPONDER_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]  a;
      logic [15:0] d;
   } word_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        go = 1'b0;
   logic        finish = 1'b0;
   logic [2:0]  addr = '0;
   logic [15:0] wdata = '0;
   logic        en = 1'b0;
   logic        wr = 1'b0;
   logic [15:0] rdata;
   logic        dump_valid;
   logic        dump_ready = 1'b0;
   logic [2:0]  dump_address;
   logic [15:0] dump_data;
   logic        dump_done;
   logic [7:0]  written_mask;
   logic        overwrite_err;
   logic        missing_err;
   logic        late_write_err;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] mem_m [8];
   logic [7:0]  mask_m = '0;
   word_t       exp_q [$];
   int          cyc;

   output_ram_responder #(.ADDR_W(3), .DATA_W(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .xxx__dut__go     (go),
      .dut__xxx__finish (finish),
      .dut__dom__address(addr),
      .dut__dom__data   (wdata),
      .dut__dom__enable (en),
      .dut__dom__write  (wr),
      .dom__dut__data   (rdata),
      .dump_valid       (dump_valid),
      .dump_ready       (dump_ready),
      .dump_address     (dump_address),
      .dump_data        (dump_data),
      .dump_done        (dump_done),
      .written_mask     (written_mask),
      .overwrite_err    (overwrite_err),
      .missing_err      (missing_err),
      .late_write_err   (late_write_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_go();
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      mask_m = '0;
   endtask

   task automatic do_write(input int a, input logic [15:0] d);
      en = 1'b1; wr = 1'b1; addr = 3'(a); wdata = d;
      @(negedge clk);
      en = 1'b0; wr = 1'b0;
      mem_m[a] = d;
      mask_m[a] = 1'b1;
   endtask

   task automatic do_read(input string tag, input int a, input logic [15:0] exp);
      en = 1'b1; wr = 1'b0; addr = 3'(a);
      @(negedge clk);
      en = 1'b0;
      check(tag, 32'(rdata), 32'(exp));
   endtask

   // Finish pulse, optionally with a same-cycle write; loads the scoreboard
   task automatic do_finish(input logic with_wr, input int a, input logic [15:0] d);
      if (with_wr) begin
         en = 1'b1; wr = 1'b1; addr = 3'(a); wdata = d;
         mem_m[a] = d;
         mask_m[a] = 1'b1;
      end
      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0; en = 1'b0; wr = 1'b0;
      for (int i = 0; i < 8; i++) exp_q.push_back('{a: 3'(i), d: mem_m[i]});
   endtask

   // Consume up to max_words dump words, stalling stall_len cycles at address stall_at
   task automatic drain(input int stall_at, input int stall_len, input int max_words,
                        output int cycles);
      int    stalled = 0;
      int    taken = 0;
      word_t w;
      cycles = 0;
      while (taken < max_words && cycles < 40) begin
         w = (exp_q.size() > 0) ? exp_q[0] : '0;
         check("dump_valid", 32'(dump_valid), 32'd1);
         check("dump_address", 32'(dump_address), 32'(w.a));
         check("dump_data", 32'(dump_data), 32'(w.d));
         if (int'(dump_address) == stall_at && stalled < stall_len) begin
            dump_ready = 1'b0;
            stalled++;
         end else begin
            dump_ready = 1'b1;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            taken++;
         end
         @(negedge clk);
         cycles++;
      end
      dump_ready = 1'b0;
   endtask

   task automatic check_flags(input string tag, input logic ovw, input logic mis, input logic late);
      check({tag, "_overwrite"}, 32'(overwrite_err), 32'(ovw));
      check({tag, "_missing"}, 32'(missing_err), 32'(mis));
      check({tag, "_late"}, 32'(late_write_err), 32'(late));
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem_m[i] = '0;

      // Reset state
      #2 reset = 1'b0;
      #1;
      check("rst_valid", 32'(dump_valid), 32'd0);
      check("rst_done", 32'(dump_done), 32'd0);
      check("rst_mask", 32'(written_mask), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check_flags("rst", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Full run with constant ready
      do_go();
      for (int i = 0; i < 8; i++) do_write(i, 16'h0100 + 16'(i));
      do_read("rd_after_wr", 7, 16'h0107);
      @(negedge clk);
      check("rd_hold", 32'(rdata), 32'h0107);
      check("full_mask", 32'(written_mask), 32'hFF);
      do_finish(1'b0, 0, '0);
      drain(-1, 0, 8, cyc);
      check("full_cycles", 32'(cyc), 32'd8);
      check("full_done", 32'(dump_done), 32'd1);
      check("full_valid_off", 32'(dump_valid), 32'd0);
      check("full_sb_empty", 32'(exp_q.size()), 32'd0);
      check_flags("full", 1'b0, 1'b0, 1'b0);
      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      check("done_ignores_finish", 32'(dump_done), 32'd1);
      do_read("rd_in_done", 2, 16'h0102);

      // Backpressure at ptr 2 for 3 cycles
      do_go();
      check("go_clears_done", 32'(dump_done), 32'd0);
      for (int i = 0; i < 8; i++) do_write(i, 16'h0100 + 16'(i));
      do_finish(1'b0, 0, '0);
      drain(2, 3, 8, cyc);
      check("bp_cycles", 32'(cyc), 32'd11);
      check("bp_done", 32'(dump_done), 32'd1);

      // Missing and overwrite, from a clean memory
      reset = 1'b0;
      for (int i = 0; i < 8; i++) mem_m[i] = '0;
      mask_m = '0;
      @(negedge clk);
      reset = 1'b1;
      do_go();
      foreach (mem_m[i]) if (i != 3 && i != 5) do_write(i, 16'h0100 + 16'(i));
      do_write(5, 16'hAAAA);
      check("ovw_not_yet", 32'(overwrite_err), 32'd0);
      do_write(5, 16'hBBBB);
      check("chk_mask", 32'(written_mask), 32'(mask_m));
      do_finish(1'b0, 0, '0);
      check_flags("chk", CHK, CHK, 1'b0);
      drain(-1, 0, 8, cyc);
      check("chk_done", 32'(dump_done), 32'd1);

      // Late write in DUMP, then restart
      do_go();
      check_flags("go_clear", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) do_write(i, 16'h0200 + 16'(i));
      do_finish(1'b0, 0, '0);
      en = 1'b1; wr = 1'b1; addr = 3'd0; wdata = 16'hFFFF;
      finish = 1'b1;
      @(negedge clk);
      en = 1'b0; wr = 1'b0; finish = 1'b0;
      check("late_flag", 32'(late_write_err), 32'(CHK));
      check("late_mask", 32'(written_mask), 32'hFF);
      drain(-1, 0, 8, cyc);
      check("late_cycles", 32'(cyc), 32'd8);
      do_read("late_mem0", 0, 16'h0200);
      do_go();
      check("restart_mask", 32'(written_mask), 32'd0);
      check("restart_done", 32'(dump_done), 32'd0);
      check("restart_valid", 32'(dump_valid), 32'd0);
      check_flags("restart", 1'b0, 1'b0, 1'b0);

      // Reset mid-dump at ptr 4
      for (int i = 0; i < 8; i++) do_write(i, 16'h0300 + 16'(i));
      do_finish(1'b0, 0, '0);
      drain(-1, 0, 4, cyc);
      check("mid_ptr", 32'(dump_address), 32'd4);
      reset = 1'b0;
      #1;
      check("mid_rst_valid", 32'(dump_valid), 32'd0);
      check("mid_rst_done", 32'(dump_done), 32'd0);
      exp_q.delete();
      for (int i = 0; i < 8; i++) mem_m[i] = '0;
      mask_m = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_no_valid", 32'(dump_valid), 32'd0);
      do_read("mid_rd4", 4, 16'h0000);
      do_read("mid_rd7", 7, 16'h0000);

      // go and finish together: stays in capture
      go = 1'b1; finish = 1'b1;
      @(negedge clk);
      go = 1'b0; finish = 1'b0;
      check("gofin_valid", 32'(dump_valid), 32'd0);
      check("gofin_done", 32'(dump_done), 32'd0);

      // go drops a same-cycle write
      go = 1'b1; en = 1'b1; wr = 1'b1; addr = 3'd1; wdata = 16'hDEAD;
      @(negedge clk);
      go = 1'b0; en = 1'b0; wr = 1'b0;
      check("go_drop_mask", 32'(written_mask), 32'd0);
      do_read("go_drop_mem", 1, mem_m[1]);

      // Write plus finish in the same cycle
      for (int i = 0; i < 7; i++) do_write(i, 16'h0400 + 16'(i));
      do_finish(1'b1, 7, 16'h7777);
      check("wf_mask", 32'(written_mask), 32'hFF);
      check("wf_missing", 32'(missing_err), 32'd0);
      drain(-1, 0, 8, cyc);
      check("wf_done", 32'(dump_done), 32'd1);
      check("wf_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: observed no completion, required completion");
      $fatal(1, "timeout");
   end

endmodule
